// File: rtl/tim_arbiter_if.sv
// Bundle of the fetch, load/store and tim buses around tim_arbiter.
// The slave modport is the arbiter's view; master is the core/tim environment.
interface tim_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  imem_valid;
  logic [ADDR_W-1:0]     imem_addr;
  logic [DATA_W-1:0]     imem_rdata;
  logic                  imem_ready;

  logic                  dmem_valid;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_wstrb;
  logic [DATA_W-1:0]     dmem_rdata;
  logic                  dmem_ready;

  logic                  tim_valid;
  logic                  tim_instr;
  logic [ADDR_W-1:0]     tim_addr;
  logic [DATA_W-1:0]     tim_wdata;
  logic [DATA_W/8-1:0]   tim_wstrb;
  logic [DATA_W-1:0]     tim_rdata;
  logic                  tim_ready;

  modport slave (
    input  imem_valid, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready,
    output tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb,
    input  tim_rdata, tim_ready
  );

  modport master (
    output imem_valid, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready,
    input  tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb,
    output tim_rdata, tim_ready
  );
endinterface

// File: rtl/tim_arbiter.sv
// Shares one single-ported tim between fetch (imem) and load/store (dmem) ports.
// Default is fixed dmem priority; define TIM_ARB_RR_EN for round-robin ties.
module tim_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  tim_arbiter_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_IMEM, GNT_DMEM} gnt_e;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } dreq_t;

  gnt_e              gnt_q;
  gnt_e              winner;
  gnt_e              tie_winner;
  logic              wr_q;
  logic              ipend_v;
  logic [ADDR_W-1:0] ipend_addr;
  dreq_t             dpend_q;
  dreq_t             dreq;
  logic [ADDR_W-1:0] iaddr;
  logic              iacc, dacc, icand, grant_ok, rsp;

`ifdef TIM_ARB_RR_EN
  gnt_e last_q;
  assign tie_winner = (last_q == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
`else
  assign tie_winner = GNT_DMEM;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    winner         = GNT_NONE;
    bus.tim_valid  = 1'b0;
    bus.tim_instr  = 1'b0;
    bus.tim_addr   = '0;
    bus.tim_wdata  = '0;
    bus.tim_wstrb  = '0;

    grant_ok = !reset && (gnt_q == GNT_NONE || bus.tim_ready);
    // A port whose access is still waiting or unanswered ignores a new valid.
    iacc = bus.imem_valid && !ipend_v   && !(gnt_q == GNT_IMEM && !bus.tim_ready);
    dacc = bus.dmem_valid && !dpend_q.v && !(gnt_q == GNT_DMEM && !bus.tim_ready);

    icand = ipend_v || iacc;
    iaddr = ipend_v ? ipend_addr : bus.imem_addr;
    dreq  = dpend_q.v ? dpend_q
                      : '{v: dacc, addr: bus.dmem_addr, wdata: bus.dmem_wdata, wstrb: bus.dmem_wstrb};

    if (grant_ok) begin
      if (icand && dreq.v) winner = tie_winner;
      else if (dreq.v)     winner = GNT_DMEM;
      else if (icand)      winner = GNT_IMEM;
    end

    case (winner)
      GNT_IMEM: begin
        bus.tim_valid = 1'b1;
        bus.tim_instr = 1'b1;
        bus.tim_addr  = iaddr;
      end
      GNT_DMEM: begin
        bus.tim_valid = 1'b1;
        bus.tim_addr  = dreq.addr;
        bus.tim_wdata = dreq.wdata;
        bus.tim_wstrb = dreq.wstrb;
      end
      default: ;
    endcase
  end

  // Responses follow the recorded grant; stores return zero data.
  assign rsp            = !reset && bus.tim_ready;
  assign bus.imem_ready = rsp && (gnt_q == GNT_IMEM);
  assign bus.imem_rdata = bus.imem_ready ? bus.tim_rdata : '0;
  assign bus.dmem_ready = rsp && (gnt_q == GNT_DMEM);
  assign bus.dmem_rdata = (bus.dmem_ready && !wr_q) ? bus.tim_rdata : '0;

  always_ff @(posedge clock) begin
    // NOTE: all state uses non-blocking assignments so updates land together.
    if (reset) begin
      gnt_q      <= GNT_NONE;
      wr_q       <= 1'b0;
      ipend_v    <= 1'b0;
      ipend_addr <= '0;
      dpend_q    <= '0;
`ifdef TIM_ARB_RR_EN
      last_q     <= GNT_IMEM;
`endif
    end else begin
      if (winner != GNT_NONE) begin
        gnt_q <= winner;
        wr_q  <= (winner == GNT_DMEM) && (dreq.wstrb != '0);
      end else if (bus.tim_ready) begin
        gnt_q <= GNT_NONE;
        wr_q  <= 1'b0;
      end
`ifdef TIM_ARB_RR_EN
      if (winner != GNT_NONE) last_q <= winner;
`endif
      if (winner == GNT_IMEM) begin
        ipend_v <= 1'b0;
      end else if (iacc) begin
        ipend_v    <= 1'b1;
        ipend_addr <= bus.imem_addr;
      end

      if (winner == GNT_DMEM) begin
        dpend_q.v <= 1'b0;
      end else if (dacc) begin
        dpend_q <= '{v: 1'b1, addr: bus.dmem_addr, wdata: bus.dmem_wdata, wstrb: bus.dmem_wstrb};
      end
    end
  end
endmodule

// File: tb/tb_tim_arbiter.sv
// Self-checking bench for tim_arbiter: directed vector table, back-to-back
// sequence and randomized traffic against a request-slot reference model.
module tb_tim_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef TIM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dws;
    logic        tr;
    logic [31:0] trd;
  } in_t;

  typedef struct packed {
    logic        tv;
    logic        ti;
    logic [31:0] ta;
    logic [31:0] twd;
    logic [3:0]  tws;
    logic        ir;
    logic [31:0] ird;
    logic        dr;
    logic [31:0] drd;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tim_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  tim_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one waiting slot per port (0=imem, 1=dmem) and the in-flight port.
  mreq_t m_wait [2];
  int    m_infl    = -1;
  bit    m_infl_wr = 1'b0;
  int    m_last    = 0;

  function automatic in_t mk_in(logic rst, logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                                logic [31:0] dwd, logic [3:0] dws, logic tr, logic [31:0] trd);
    return '{rst: rst, iv: iv, ia: ia, dv: dv, da: da, dwd: dwd, dws: dws, tr: tr, trd: trd};
  endfunction

  function automatic out_t mk_out(logic tv, logic ti, logic [31:0] ta, logic [31:0] twd, logic [3:0] tws,
                                  logic ir, logic [31:0] ird, logic dr, logic [31:0] drd);
    return '{tv: tv, ti: ti, ta: ta, twd: twd, tws: tws, ir: ir, ird: ird, dr: dr, drd: drd};
  endfunction

  task automatic apply(input in_t x);
    reset          = x.rst;
    bus.imem_valid = x.iv;
    bus.imem_addr  = x.ia;
    bus.dmem_valid = x.dv;
    bus.dmem_addr  = x.da;
    bus.dmem_wdata = x.dwd;
    bus.dmem_wstrb = x.dws;
    bus.tim_ready  = x.tr;
    bus.tim_rdata  = x.trd;
  endtask

  function automatic out_t sample();
    out_t o;
    o.tv  = bus.tim_valid;
    o.ti  = bus.tim_instr;
    o.ta  = bus.tim_addr;
    o.twd = bus.tim_wdata;
    o.tws = bus.tim_wstrb;
    o.ir  = bus.imem_ready;
    o.ird = bus.imem_rdata;
    o.dr  = bus.dmem_ready;
    o.drd = bus.dmem_rdata;
    return o;
  endfunction

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs on the falling edge and return outputs sampled 1 time unit later.
  task automatic cycle(input in_t x, output out_t y);
    @(negedge clock);
    apply(x);
    #1;
    y = sample();
  endtask

  task automatic model_step(input in_t x, output out_t e);
    mreq_t nreq [2];
    bit    acc  [2];
    bit    cand [2];
    int    win;
    e = '0;
    if (x.rst) begin
      m_wait[0].v = 1'b0;
      m_wait[1].v = 1'b0;
      m_infl      = -1;
      m_infl_wr   = 1'b0;
      m_last      = 0;
      return;
    end
    if (x.tr && m_infl == 0) begin e.ir = 1'b1; e.ird = x.trd; end
    if (x.tr && m_infl == 1) begin e.dr = 1'b1; e.drd = m_infl_wr ? 32'h0 : x.trd; end
    nreq[0] = '{v: 1'b1, addr: x.ia, wdata: 32'h0, wstrb: 4'h0};
    nreq[1] = '{v: 1'b1, addr: x.da, wdata: x.dwd, wstrb: x.dws};
    acc[0]  = x.iv && !m_wait[0].v && !(m_infl == 0 && !x.tr);
    acc[1]  = x.dv && !m_wait[1].v && !(m_infl == 1 && !x.tr);
    for (int p = 0; p < 2; p++) begin
      cand[p] = m_wait[p].v || acc[p];
      if (acc[p]) m_wait[p] = nreq[p];
    end
    win = -1;
    if (m_infl == -1 || x.tr) begin
      if (cand[0] && cand[1]) win = RR ? ((m_last == 0) ? 1 : 0) : 1;
      else if (cand[1])       win = 1;
      else if (cand[0])       win = 0;
    end
    if (win >= 0) begin
      e.tv = 1'b1;
      e.ti = (win == 0);
      e.ta = m_wait[win].addr;
      if (win == 1) begin
        e.twd = m_wait[1].wdata;
        e.tws = m_wait[1].wstrb;
      end
      m_wait[win].v = 1'b0;
      m_infl        = win;
      m_infl_wr     = (win == 1) && (m_wait[1].wstrb != 4'h0);
      m_last        = win;
    end else if (x.tr) begin
      m_infl = -1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [$];
    out_t  y, e;
    in_t   x;
    bit    t_busy, t_wr;
    logic [32:0] b2b_exp_addr [6];
    logic        b2b_exp_ir   [6];
    logic [31:0] b2b_da       [6];

    apply(mk_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- directed vector table (one row per cycle) ----------------
    tbl.push_back('{mk_in(1, 1, 'h100, 1, 'h300, 0, 0, 1, 'h99),          mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h100, 0, 0, 0, 0, 0, 0),                 mk_out(1, 1, 'h100, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF),            mk_out(0, 0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h200, 1, 'h300, 0, 0, 0, 0),             mk_out(1, 0, 'h300, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h11111111),            mk_out(1, 1, 'h200, 0, 0, 0, 0, 1, 'h11111111)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h22222222),            mk_out(0, 0, 0, 0, 0, 1, 'h22222222, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 'h40, 'h12345678, 'hF, 0, 0),       mk_out(1, 0, 'h40, 'h12345678, 'hF, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0),                     mk_out(0, 0, 0, 0, 0, 0, 0, 1, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 'h80, 0, 0, 0, 0),                  mk_out(1, 0, 'h80, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h500, 0, 0, 0, 0, 0, 0),                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0),                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h33333333),            mk_out(1, 1, 'h500, 0, 0, 0, 0, 1, 'h33333333)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h44444444),            mk_out(0, 0, 0, 0, 0, 1, 'h44444444, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 'h60, 0, 0, 0, 0),                  mk_out(1, 0, 'h60, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(1, 1, 'h700, 0, 0, 0, 0, 1, 'h55555555),        mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h104, 0, 0, 0, 0, 0, 0),                 mk_out(1, 1, 'h104, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h66666666),            mk_out(0, 0, 0, 0, 0, 1, 'h66666666, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h108, 0, 0, 0, 0, 0, 0),                 mk_out(1, 1, 'h108, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 1, 'h10C, 0, 0, 0, 0, 0, 0),                 mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h77),                  mk_out(0, 0, 0, 0, 0, 1, 'h77, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 1, 'h88),                  mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)});

    foreach (tbl[k]) begin
      cycle(tbl[k].i, y);
      check($sformatf("vec%0d", k), 136'(y), 136'(tbl[k].o));
    end

    // ---------------- back-to-back dmem with one fetch ----------------
    b2b_da = '{'hA00, 'hA04, 'hA08, 'hA0C, 0, 0};
    if (RR) begin
      b2b_exp_addr = '{{1'b1, 32'hA00}, {1'b1, 32'hB00}, {1'b1, 32'hA04}, {1'b1, 32'hA0C}, 33'h0, 33'h0};
      b2b_exp_ir   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    end else begin
      b2b_exp_addr = '{{1'b1, 32'hA00}, {1'b1, 32'hA04}, {1'b1, 32'hA08}, {1'b1, 32'hA0C}, {1'b1, 32'hB00}, 33'h0};
      b2b_exp_ir   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end
    cycle(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0), y);
    check("b2b_reset", 136'(y), 136'(0));
    for (int c = 0; c < 6; c++) begin
      x = mk_in(0, c == 0, 'hB00, c < 4, b2b_da[c], 0, 0, c != 0, 32'hC0DE0000 + 32'(c));
      cycle(x, y);
      check($sformatf("b2b_addr_c%0d", c + 1), 136'({y.tv, y.ta}), 136'(b2b_exp_addr[c]));
      check($sformatf("b2b_iready_c%0d", c + 1), 136'(y.ir), 136'(b2b_exp_ir[c]));
    end

    // ---------------- randomized traffic against the reference model ----------------
    t_busy = 1'b0;
    t_wr   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      x.rst = (n == 0) || ($urandom % 97 == 0);
      x.iv  = ($urandom % 3 == 0);
      x.ia  = $urandom & 32'hFFFF_FFFC;
      x.dv  = ($urandom % 3 == 0);
      x.da  = $urandom & 32'hFFFF_FFFC;
      x.dwd = $urandom;
      x.dws = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      x.tr  = t_busy ? ($urandom % 4 != 0) : ($urandom % 20 == 0);
      x.trd = (t_busy && t_wr) ? 32'h0 : $urandom;
      cycle(x, y);
      model_step(x, e);
      check($sformatf("rand%0d", n), 136'(y), 136'(e));
      if (x.tr) t_busy = 1'b0;
      if (y.tv) begin
        t_busy = 1'b1;
        t_wr   = (y.tws != 4'h0);
      end
    end

    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tim_arbiter.md
Name: tim_arbiter

Overview:
- Two-port arbiter that shares the single-ported tightly integrated memory (tim) between the instruction-fetch port (imem) and the load/store port (dmem).
- Sits between the core's two memory interfaces and one tim instance.
- Buffers a losing request, grants one access per cycle and routes the one-cycle-latency response back to the issuing port.
- Pipelined: a new grant may issue in the same cycle the previous response returns.

Parameters:
- ADDR_W, 32, byte-address width forwarded to tim_addr.
- DATA_W, 32, data width. Only 32 is supported; wstrb is DATA_W/8 = 4 bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_valid  in  1  fetch request pulse (one cycle)
- imem_addr  in  ADDR_W  fetch address
- imem_rdata  out  DATA_W  fetch data, valid when imem_ready=1
- imem_ready  out  1  one-cycle completion pulse
- dmem_valid  in  1  load/store request pulse (one cycle)
- dmem_addr  in  ADDR_W  data address
- dmem_wdata  in  DATA_W  store data
- dmem_wstrb  in  4  byte strobes; 0 = load
- dmem_rdata  out  DATA_W  load data, valid when dmem_ready=1
- dmem_ready  out  1  one-cycle completion pulse
- tim_valid  out  1  request to tim
- tim_instr  out  1  1 = fetch access
- tim_addr  out  ADDR_W  tim address
- tim_wdata  out  DATA_W  tim write data
- tim_wstrb  out  4  tim strobes
- tim_rdata  in  DATA_W  tim read data
- tim_ready  in  1  tim completion (cycle after tim_valid)

Behaviour:
- Requester rule: each port pulses valid for one cycle and issues nothing new until its ready. A second valid before ready is a protocol violation and is ignored (not latched).
- Pending buffers: one entry per port (pend_v, addr, wdata, wstrb). An incoming valid that is not granted that cycle is latched into its buffer.
- Candidate per port = pend_v OR valid. The buffered copy is used if pend_v=1.
- Grant allowed when gnt_q = NONE or tim_ready = 1.
  - gnt_q is a 2-state-plus-idle register: NONE / IMEM / DMEM, recording the outstanding access.
- On a grant, tim_* are driven combinationally in the same cycle:
  - tim_valid=1.
  - Fields come from the granted source.
  - tim_instr=1 and tim_wstrb=0 for imem.
- Registered effects of a grant: gnt_q <= winner; the winner's pend_v is cleared.
- No grant (no candidate, or stalled): tim_valid=0, tim_addr/wdata/wstrb/instr=0. gnt_q <= NONE if tim_ready=1, else unchanged.
- Response routing:
  - When tim_ready=1, the port named by gnt_q gets ready=1 and rdata=tim_rdata.
  - The other port gets ready=0, rdata=0.
  - tim_ready while gnt_q=NONE is dropped.
- Stall: if gnt_q≠NONE and tim_ready=0, no new grant is made; incoming requests are latched.
- Arbitration (default): fixed priority, dmem over imem.
- Latency:
  - Uncontended request: ready one cycle after valid.
  - Loser of contention: ready two cycles after valid.
- Reset: pend_v=0 on both ports, gnt_q=NONE, all outputs 0. valid asserted in the same cycle as reset is dropped. A response in flight when reset asserts is discarded.
- Writes: dmem store completes with dmem_ready=1, dmem_rdata=0.

Optional Feature:
- Macro: TIM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_q flop records the last granted port.
  - On contention the port not equal to last_q wins.
  - last_q resets to IMEM, so dmem wins the first tie.
  - Back-to-back dmem traffic cannot starve imem: imem waits at most 2 cycles.
- Undefined: fixed dmem priority, and no last_q flop exists.

Test Plan:
- Single fetch: imem_valid, addr 0x100 at cycle 1.
  - Cycle 1: tim_valid=1, tim_instr=1, tim_addr=0x100.
  - Cycle 2: tim_rdata=0xDEADBEEF → imem_ready=1, imem_rdata=0xDEADBEEF, dmem_ready=0.
- Collision: imem 0x200 and dmem load 0x300 both valid at cycle 1.
  - Cycle 1 tim_addr=0x300; cycle 2 tim_addr=0x200 from the buffer.
  - dmem_ready at cycle 2, imem_ready at cycle 3.
- Store: dmem addr 0x40, wdata 0x12345678, wstrb 0xF → tim_wstrb=0xF, tim_instr=0; next cycle dmem_ready=1, dmem_rdata=0.
- Back-to-back: dmem valid every cycle for 4 cycles, imem valid at cycle 1.
  - Fixed priority: imem_ready stays 0 throughout.
  - With TIM_ARB_RR_EN: tim_addr alternates dmem/imem and imem_ready=1 at cycle 3.
- Stall: grant at cycle 1 with tim_ready held 0 for 2 cycles while imem valid at cycle 2.
  - tim_valid=0 until tim_ready=1.
  - imem is granted in that same cycle and its ready follows one cycle later.
- Reset mid-flight: dmem granted at cycle 1, reset=1 at cycle 2 → dmem_ready=0 and all outputs 0 during reset; a fresh imem request after reset completes in 1 cycle.
